data_cache_sa: RTL
==================

# data_cache_sa

Parametrised set-associative data cache between the processor's memory stage and the backing data memory. Replaces the fixed 16-line combinational cache with a clocked block that has valid bits, round-robin replacement and a request/response handshake on both sides. Reads allocate on miss. Writes are write-through and no-write-allocate.

## Interface
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, word width; one word per line.
- `SETS`, 8, number of sets; power of two, ≥2.
- `WAYS`, 2, associativity; power of two, ≥1.
- `OFFSET_W`, 2, byte-offset bits ignored for lookup.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req_valid` in 1: CPU request present.
- `cpu_req_ready` out 1: high only in IDLE.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: byte address.
- `cpu_wdata` in DATA_W: write data.
- `cpu_rvalid` out 1: one-cycle completion pulse for reads and writes.
- `cpu_rdata` out DATA_W: read data, valid with `cpu_rvalid`.
- `cpu_hit` out 1: lookup hit, valid with `cpu_rvalid`.
- `mem_req_valid` out 1: memory request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDR_W: word-aligned address (offset bits zero).
- `mem_wdata` out DATA_W: memory write data.
- `mem_rvalid` in 1: memory read data valid.
- `mem_rdata` in DATA_W: memory read data.
- `hit_count`, `miss_count` out 32: present only with `DCACHE_STATS_EN`.

## Operation
- Address split:
  - index = `cpu_addr[OFFSET_W +: IDX_W]`, with IDX_W = log2(SETS).
  - tag = the remaining upper bits, TAG_W = ADDR_W − IDX_W − OFFSET_W.
- Per line: valid, tag, data. Per set: a log2(WAYS)-bit round-robin pointer.
- States:
  - IDLE: accept the request.
  - LOOKUP: compare all ways in parallel.
  - MEM_REQ: hold the memory request until accepted.
  - MEM_WAIT: wait for read data.
  - RESP: pulse the completion.
- Read hit: IDLE → LOOKUP → RESP. Returns way data with `cpu_hit` = 1.
- Read miss: LOOKUP → MEM_REQ (`mem_we` = 0) → MEM_WAIT → RESP.
  - On `mem_rvalid`: fill the victim (valid = 1, tag, data) and return `mem_rdata` with `cpu_hit` = 0.
- Victim selection:
  - If any way is invalid, use the lowest-index invalid way; the pointer is unchanged.
  - Otherwise use the way at `ptr[set]`, then increment the pointer modulo WAYS.
- Write, hit or miss: LOOKUP → MEM_REQ (`mem_we` = 1, `mem_wdata` = `cpu_wdata`) → RESP once `mem_req_ready` is seen.
  - On a hit, update the hit way's data in LOOKUP.
  - On a miss, leave the cache unchanged.
- More than one way matching is impossible by construction; the lowest index wins if it occurs.
- `mem_rvalid` outside MEM_WAIT is ignored.
- `cpu_req_valid` outside IDLE is ignored; the request must be held until `cpu_req_ready`.

## Timing
- Request accepted at edge T (`cpu_req_valid` & `cpu_req_ready`).
  - Hit read: `cpu_rvalid` is high in cycle T+2.
  - Miss read: `cpu_rvalid` is high in the cycle after the edge that samples `mem_rvalid`.
- `mem_req_valid` asserts in the cycle after LOOKUP. It stays high, with address, `mem_we` and `mem_wdata` stable, until the edge where `mem_req_ready` = 1, and drops the following cycle.
- `cpu_rvalid` is a single cycle. `cpu_rdata` and `cpu_hit` hold their value until the next RESP.
- Reset values:
  - All valid bits and pointers 0; state IDLE.
  - `cpu_req_ready` = 1 from the first cycle after reset.
  - `cpu_rvalid`, `cpu_hit`, `mem_req_valid`, `mem_we` = 0.
  - `cpu_rdata`, `mem_addr`, `mem_wdata` = 0; counters 0.
- Reset mid-operation: reset dominates every state. No fill occurs and no `cpu_rvalid` is produced for the abandoned request.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` / `miss_count` ports exist.
  - The matching counter increments in LOOKUP for every read and write.
  - Counters wrap at 2^32 and clear on `rst`.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package `dcache_pkg`: state enum (IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP) and a `clog2`-style width function.
- Sub-module `dcache_victim_sel`: combinational victim selection from the set's valid vector and pointer, producing the victim way and the next pointer.

## Test plan
Default parameters, memory model with a 3-cycle read latency.
- Read miss then hit:
  - After reset, read 0x40 → miss; `mem_addr` = 0x40, `mem_we` = 0; response 0xDEADBEEF with `cpu_hit` = 0.
  - Re-read 0x40 → `cpu_rvalid` at T+2, 0xDEADBEEF, `cpu_hit` = 1, no `mem_req_valid`.
- Write hit:
  - Write 0x12345678 to 0x43 → `mem_addr` = 0x40, `mem_wdata` = 0x12345678, `mem_we` = 1.
  - Next read of 0x40 → hit, 0x12345678.
- Write miss:
  - Write 0x80 → memory write issued; cache untouched.
  - Read 0x80 → `cpu_hit` = 0.
- Replacement:
  - Read 0x00, 0x20, 0x40 (all set 0) → 0x00 to way 0, 0x20 to way 1, 0x40 evicts way 0 and the pointer becomes 1.
  - Read 0x20 → hit; read 0x00 → miss.
- Handshake and reset:
  - Hold `mem_req_ready` low for 5 cycles → request fields stable throughout.
  - Assert `rst` during MEM_WAIT → IDLE next cycle, `cpu_req_ready` = 1, late `mem_rvalid` ignored, no `cpu_rvalid`; read 0x40 → miss.
- Stats (`DCACHE_STATS_EN`): after the first scenario → `hit_count` = 1, `miss_count` = 1.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the set-associative data cache.
// Provides the controller state enum and log2-style width helpers.
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } stateT;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Way-pointer width; a direct-mapped cache still needs one bit.
    function automatic int ptrWidth(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// dcache_victim_sel: picks the fill way for one set.
// Ports: validVec/ptr in, victim way and updated round-robin ptr out.
module dcache_victim_sel
    import dcache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int PTR_W = 1
) (
    input  logic [WAYS-1:0]  validVec,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] victim,
    output logic [PTR_W-1:0] nextPtr
);

    always_comb begin
        victim  = ptr;
        nextPtr = (ptr == PTR_W'(WAYS - 1)) ? '0 : ptr + 1'b1;
        // Descending scan so the lowest invalid way is the last to win.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validVec[w]) victim = PTR_W'(w);
        end
        // Filling an empty way leaves the round-robin pointer alone.
        if (!(&validVec)) nextPtr = ptr;
    end

endmodule

// File: rtl/data_cache_sa.sv
// data_cache_sa: set-associative, write-through, no-write-allocate D-cache.
// CPU side: cpu_req_*/cpu_we/cpu_addr/cpu_wdata in, cpu_rvalid/rdata/hit out.
// Memory side: mem_req_valid/we/addr/wdata out, mem_req_ready/rvalid/rdata in.
// Define DCACHE_STATS_EN to add the hit_count/miss_count ports.
module data_cache_sa
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int OFFSET_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = clog2(SETS);
    localparam int WA_W  = ADDR_W - OFFSET_W;
    localparam int TAG_W = WA_W - IDX_W;
    localparam int PTR_W = ptrWidth(WAYS);

    stateT state, nextState;

    logic [WAYS-1:0]   validArr [SETS];
    logic [PTR_W-1:0]  ptrArr   [SETS];
    logic [TAG_W-1:0]  tagArr   [SETS][WAYS];
    logic [DATA_W-1:0] dataArr  [SETS][WAYS];

    logic              reqWe;
    logic              reqHit;
    logic [WA_W-1:0]   reqWord;
    logic [DATA_W-1:0] reqWdata;
    logic [IDX_W-1:0]  reqIdx;
    logic [TAG_W-1:0]  reqTag;

    logic              hitAny;
    logic [PTR_W-1:0]  hitWay;
    logic [PTR_W-1:0]  victimWay;
    logic [PTR_W-1:0]  nextPtr;
    logic              unusedOffset;

    // Byte-offset bits never take part in lookup.
    assign unusedOffset = ^cpu_addr[OFFSET_W-1:0];

    assign reqIdx = reqWord[IDX_W-1:0];
    assign reqTag = reqWord[WA_W-1:IDX_W];

    assign cpu_req_ready = (state == IDLE);
    assign cpu_rvalid    = (state == RESP);

    always_comb begin
        hitAny = 1'b0;
        hitWay = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (validArr[reqIdx][w] && tagArr[reqIdx][w] == reqTag) begin
                hitAny = 1'b1;
                hitWay = PTR_W'(w);
            end
        end
    end

    dcache_victim_sel #(
        .WAYS  (WAYS),
        .PTR_W (PTR_W)
    ) uVictim (
        .validVec (validArr[reqIdx]),
        .ptr      (ptrArr[reqIdx]),
        .victim   (victimWay),
        .nextPtr  (nextPtr)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:     if (cpu_req_valid) nextState = LOOKUP;
            LOOKUP:   nextState = (!reqWe && hitAny) ? RESP : MEM_REQ;
            MEM_REQ:  if (mem_req_ready) nextState = reqWe ? RESP : MEM_WAIT;
            MEM_WAIT: if (mem_rvalid) nextState = RESP;
            RESP:     nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                validArr[s] <= '0;
                ptrArr[s]   <= '0;
            end
            reqWe         <= 1'b0;
            reqHit        <= 1'b0;
            reqWord       <= '0;
            reqWdata      <= '0;
            cpu_rdata     <= '0;
            cpu_hit       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        reqWe    <= cpu_we;
                        reqWord  <= cpu_addr[ADDR_W-1:OFFSET_W];
                        reqWdata <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    reqHit <= hitAny;
                    if (!reqWe && hitAny) begin
                        cpu_rdata <= dataArr[reqIdx][hitWay];
                        cpu_hit   <= 1'b1;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_we        <= reqWe;
                        mem_addr      <= {reqWord, {OFFSET_W{1'b0}}};
                        mem_wdata     <= reqWdata;
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_we        <= 1'b0;
                        if (reqWe) cpu_hit <= reqHit;
                    end
                end
                MEM_WAIT: begin
                    if (mem_rvalid) begin
                        validArr[reqIdx][victimWay] <= 1'b1;
                        ptrArr[reqIdx]              <= nextPtr;
                        cpu_rdata                   <= mem_rdata;
                        cpu_hit                     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == LOOKUP && reqWe && hitAny) begin
                dataArr[reqIdx][hitWay] <= reqWdata;
            end
            if (state == MEM_WAIT && mem_rvalid) begin
                tagArr[reqIdx][victimWay]  <= reqTag;
                dataArr[reqIdx][victimWay] <= mem_rdata;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hitAny) hit_count  <= hit_count + 32'd1;
            else        miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
